// File: rtl/actuator_pkg.sv
// Shared definitions for the actuator command frame transmitter:
// payload bit layout, serial FSM states and frame helper functions.
package actuator_pkg;

  localparam int AIRCON_LSB = 13;
  localparam int WIN3_BIT   = 12;
  localparam int WIN4_BIT   = 11;
  localparam int WIN5_BIT   = 10;
  localparam int WIN6_BIT   = 9;
  localparam int SUN_BIT    = 8;
  localparam int WIPER_LSB  = 6;
  localparam int HANDLE_LSB = 4;
  localparam int ENGINE_LSB = 0;

  localparam logic [7:0] DEFAULT_HEADER = 8'hA5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Bit 15 is reserved and always transmitted as 0.
  function automatic logic [15:0] pack_payload(
    input logic [1:0] aircon,
    input logic       win3,
    input logic       win4,
    input logic       win5,
    input logic       win6,
    input logic       sun,
    input logic [1:0] wiper,
    input logic [1:0] handle,
    input logic [3:0] engine
  );
    logic [15:0] p;
    p = 16'h0000;
    p[AIRCON_LSB +: 2] = aircon;
    p[WIN3_BIT]        = win3;
    p[WIN4_BIT]        = win4;
    p[WIN5_BIT]        = win5;
    p[WIN6_BIT]        = win6;
    p[SUN_BIT]         = sun;
    p[WIPER_LSB +: 2]  = wiper;
    p[HANDLE_LSB +: 2] = handle;
    p[ENGINE_LSB +: 4] = engine;
    return p;
  endfunction

  function automatic logic [7:0] xor_checksum(
    input logic [7:0] b0,
    input logic [7:0] b1,
    input logic [7:0] b2
  );
    return b0 ^ b1 ^ b2;
  endfunction

endpackage

// File: rtl/actuator_frame_tx_uart_byte_tx.sv
// UART-style byte serialiser: start bit, 8 data bits LSB first, stop bit.
// ready is high in IDLE and on the last stop-bit cycle so bytes can be chained with no gap.
module uart_byte_tx
  import actuator_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};

  tx_state_e     state_r, state_n;
  logic [TW-1:0] timer_r, timer_n;
  logic [2:0]    bit_r, bit_n;
  logic [7:0]    shift_r, shift_n;
  logic          tx_r, tx_n;
  logic          tick_s;

  // Next-state, bit timer and line level for the serial FSM
  always_comb begin
    state_n = state_r;
    timer_n = timer_r;
    bit_n   = bit_r;
    shift_n = shift_r;
    tx_n    = tx_r;
    tick_s  = (timer_r == TIMER_LAST);
    ready   = (state_r == IDLE) || ((state_r == STOP) && tick_s);
    case (state_r)
      IDLE: begin
        timer_n = TIMER_ZERO;
        if (load) begin
          state_n = START;
          shift_n = data;
          tx_n    = 1'b0;
        end else begin
          tx_n = 1'b1;
        end
      end
      START: begin
        if (tick_s) begin
          state_n = DATA;
          timer_n = TIMER_ZERO;
          bit_n   = 3'd0;
          tx_n    = shift_r[0];
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      DATA: begin
        if (tick_s) begin
          timer_n = TIMER_ZERO;
          if (bit_r == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_n   = bit_r + 3'd1;
            shift_n = {1'b0, shift_r[7:1]};
            tx_n    = shift_r[1];
          end
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      STOP: begin
        if (tick_s) begin
          timer_n = TIMER_ZERO;
          if (load) begin
            state_n = START;
            shift_n = data;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          timer_n = timer_r + TW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = TIMER_ZERO;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Serial FSM state register; reset forces the line high at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      timer_r <= TIMER_ZERO;
      bit_r   <= 3'd0;
      shift_r <= 8'h00;
      tx_r    <= 1'b1;
    end else begin
      state_r <= state_n;
      timer_r <= timer_n;
      bit_r   <= bit_n;
      shift_r <= shift_n;
      tx_r    <= tx_n;
    end
  end

  assign tx = tx_r;

endmodule

// File: rtl/actuator_frame_tx.sv
// Actuator command frame transmitter: snapshots the command vector on change,
// force_send or periodic refresh and sends HEADER, payload hi/lo and XOR checksum.
module actuator_frame_tx
  import actuator_pkg::*;
#(
  parameter int         CLKS_PER_BIT   = 8,
  parameter int         REFRESH_CYCLES = 1024,
  parameter logic [7:0] HEADER         = DEFAULT_HEADER
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] aircon,
  input  logic       win3,
  input  logic       win4,
  input  logic       win5,
  input  logic       win6,
  input  logic       sun,
  input  logic [1:0] wiper,
  input  logic [1:0] handle,
  input  logic [3:0] engine,
  input  logic       force_send,
  output logic       tx,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_ZERO = {RW{1'b0}};
  localparam logic [RW-1:0] REFRESH_MAX  = (REFRESH_CYCLES > 0) ? RW'(REFRESH_CYCLES - 1) : REFRESH_ZERO;
  localparam logic REFRESH_EN = (REFRESH_CYCLES != 0);

  logic [15:0]   payload_s;
  logic [15:0]   snap_r;
  logic [15:0]   last_sent_r;
  logic [RW-1:0] refresh_cnt_r;
  logic          pending_force_r;
  logic          busy_r;
  logic          frame_done_r;
  logic [7:0]    frame_count_r;
  logic [1:0]    byte_idx_r;
  logic          byte_ready_s;
  logic          refresh_hit_s;
  logic          send_s;
  logic          chain_s;
  logic          load_s;
  logic [7:0]    byte_data_s;

  assign payload_s = pack_payload(aircon, win3, win4, win5, win6, sun, wiper, handle, engine);

  // Send decision and selection of the byte handed to the serialiser
  always_comb begin
    refresh_hit_s = REFRESH_EN && (refresh_cnt_r == REFRESH_MAX);
    send_s        = !busy_r && ((payload_s != last_sent_r) || pending_force_r ||
                                force_send || refresh_hit_s);
    chain_s       = busy_r && byte_ready_s;
    load_s        = send_s || (chain_s && (byte_idx_r != 2'd3));
    if (send_s) begin
      byte_data_s = HEADER;
    end else begin
      case (byte_idx_r)
        2'd0:    byte_data_s = snap_r[15:8];
        2'd1:    byte_data_s = snap_r[7:0];
        2'd2:    byte_data_s = xor_checksum(HEADER, snap_r[15:8], snap_r[7:0]);
        default: byte_data_s = HEADER;
      endcase
    end
  end

  // Frame sequencing: snapshot at start, byte index while busy, completion bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r        <= 1'b0;
      byte_idx_r    <= 2'd0;
      snap_r        <= 16'h0000;
      last_sent_r   <= 16'h0000;
      frame_done_r  <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      frame_done_r <= 1'b0;
      if (send_s) begin
        busy_r      <= 1'b1;
        byte_idx_r  <= 2'd0;
        snap_r      <= payload_s;
        last_sent_r <= payload_s;
      end else if (chain_s) begin
        if (byte_idx_r == 2'd3) begin
          busy_r        <= 1'b0;
          frame_done_r  <= 1'b1;
          frame_count_r <= frame_count_r + 8'd1;
        end else begin
          byte_idx_r <= byte_idx_r + 2'd1;
        end
      end
    end
  end

  // Refresh timer and latched force requests; both clear when a frame starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_cnt_r   <= REFRESH_ZERO;
      pending_force_r <= 1'b0;
    end else if (send_s) begin
      refresh_cnt_r   <= REFRESH_ZERO;
      pending_force_r <= 1'b0;
    end else begin
      if (force_send) begin
        pending_force_r <= 1'b1;
      end
      if (!busy_r && (refresh_cnt_r != REFRESH_MAX)) begin
        refresh_cnt_r <= refresh_cnt_r + RW'(1);
      end
    end
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk  (clk),
    .reset(reset),
    .load (load_s),
    .data (byte_data_s),
    .ready(byte_ready_s),
    .tx   (tx)
  );

  assign busy        = busy_r;
  assign frame_done  = frame_done_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_actuator_frame_tx.sv
// Scoreboard bench for actuator_frame_tx: expected frames are queued as stimulus is
// applied; a line monitor decodes tx, checks bit timing and compares each frame.
module tb_actuator_frame_tx;

  logic       clk;
  logic       reset;
  logic [1:0] aircon;
  logic       win3, win4, win5, win6, sun;
  logic [1:0] wiper;
  logic [1:0] handle;
  logic [3:0] engine;
  logic       force_send;
  logic       tx, busy, frame_done;
  logic [7:0] frame_count;

  typedef struct packed {
    logic [31:0] bytes;
    logic [7:0]  cnt;
    logic        b2b;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] exp_cnt;
  int         vec_cnt;
  int         err_cnt;

  actuator_frame_tx dut (
    .clk        (clk),
    .reset      (reset),
    .aircon     (aircon),
    .win3       (win3),
    .win4       (win4),
    .win5       (win5),
    .win6       (win6),
    .sun        (sun),
    .wiper      (wiper),
    .handle     (handle),
    .engine     (engine),
    .force_send (force_send),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] bytes, input logic b2b);
    exp_t e;
    exp_cnt = exp_cnt + 8'd1;
    e.bytes = bytes;
    e.cnt   = exp_cnt;
    e.b2b   = b2b;
    exp_q.push_back(e);
  endtask

  task automatic pulse_force();
    force_send = 1'b1;
    @(negedge clk);
    force_send = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, busy}, {31'd0, lvl});
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, exp_q.size(), 32'd0);
  endtask

  // Line monitor: decodes every complete frame and compares it with the scoreboard
  initial begin : monitor
    int          since_done;
    int          gap;
    logic [31:0] got;
    logic        bitv;
    logic        bad_timing, bad_busy, aborted, check_low;
    exp_t        e;
    since_done = 1000;
    check_low  = 1'b0;
    forever begin
      @(negedge clk);
      if (since_done < 1000) since_done++;
      if (check_low) begin
        check_eq("done_pulse_width", {31'd0, frame_done}, 32'd0);
        check_low = 1'b0;
      end
      if (reset === 1'b0 && tx === 1'b0) begin
        gap        = since_done;
        got        = 32'd0;
        bitv       = 1'b0;
        bad_timing = 1'b0;
        bad_busy   = 1'b0;
        aborted    = 1'b0;
        for (int k = 0; k < 40 && !aborted; k++) begin
          for (int j = 0; j < 8 && !aborted; j++) begin
            if (k != 0 || j != 0) @(negedge clk);
            if (reset !== 1'b0) begin
              aborted = 1'b1;
            end else begin
              if (j == 0) bitv = tx;
              else if (tx !== bitv) bad_timing = 1'b1;
              if (busy !== 1'b1) bad_busy = 1'b1;
            end
          end
          if (!aborted) begin
            if (k % 10 == 0) begin
              if (bitv !== 1'b0) bad_timing = 1'b1;
            end else if (k % 10 == 9) begin
              if (bitv !== 1'b1) bad_timing = 1'b1;
            end else begin
              got[(3 - k / 10) * 8 + (k % 10 - 1)] = bitv;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          since_done = 0;
          check_low  = 1'b1;
          check_eq("frame_done", {31'd0, frame_done}, 32'd1);
          check_eq("busy_after_frame", {31'd0, busy}, 32'd0);
          check_eq("bit_framing", {31'd0, bad_timing}, 32'd0);
          check_eq("busy_in_frame", {31'd0, bad_busy}, 32'd0);
          check_eq("expected_frame_queued", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_eq("frame_bytes", got, e.bytes);
            check_eq("frame_count", {24'd0, frame_count}, {24'd0, e.cnt});
            if (e.b2b) check_eq("first_idle_start", gap, 32'd1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    exp_cnt = 8'd0;
    reset = 1'b1;
    {aircon, win3, win4, win5, win6, sun, wiper, handle, engine} = 16'd0;
    force_send = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_tx", {31'd0, tx}, 32'd1);
    check_eq("reset_busy", {31'd0, busy}, 32'd0);
    check_eq("reset_done", {31'd0, frame_done}, 32'd0);
    check_eq("reset_count", {24'd0, frame_count}, 32'd0);
    reset = 1'b0;

    // Refresh of the all-zero vector
    push_exp(32'hA50000A5, 1'b0);
    begin
      logic low_seen;
      low_seen = 1'b0;
      repeat (1000) begin
        @(negedge clk);
        if (tx !== 1'b1 || busy !== 1'b0) low_seen = 1'b1;
      end
      check_eq("refresh_quiet", {31'd0, low_seen}, 32'd0);
    end
    wait_done(2000, "refresh_frame");

    // Vector change
    engine = 4'b0101;
    handle = 2'b01;
    push_exp(32'hA50015B0, 1'b0);
    wait_done(1000, "change_frame");

    // Change mid-frame is held off until the next frame
    engine = 4'b0000;
    handle = 2'b00;
    aircon = 2'b11;
    win3   = 1'b1;
    sun    = 1'b1;
    push_exp(32'hA57100D4, 1'b0);
    wait_busy(1'b1, 20, "start_latency");
    repeat (50) @(negedge clk);
    engine = 4'b0001;
    push_exp(32'hA57101D5, 1'b1);
    wait_done(1500, "midframe_change");

    // Two force requests while busy collapse into one extra frame
    pulse_force();
    push_exp(32'hA57101D5, 1'b0);
    wait_busy(1'b1, 20, "force_idle_start");
    repeat (30) @(negedge clk);
    pulse_force();
    repeat (40) @(negedge clk);
    pulse_force();
    push_exp(32'hA57101D5, 1'b1);
    wait_done(1500, "force_collapse");
    repeat (100) @(negedge clk);
    check_eq("no_extra_frame", {31'd0, busy}, 32'd0);

    // Asynchronous reset at bit 20 aborts the frame
    pulse_force();
    wait_busy(1'b1, 20, "abort_frame_start");
    repeat (160) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("async_reset_tx", {31'd0, tx}, 32'd1);
    check_eq("async_reset_busy", {31'd0, busy}, 32'd0);
    check_eq("async_reset_count", {24'd0, frame_count}, 32'd0);
    exp_cnt = 8'd0;
    @(negedge clk);
    @(negedge clk);
    push_exp(32'hA57101D5, 1'b0);
    reset = 1'b0;

    // Chained forced frames until frame_count wraps
    wait_busy(1'b1, 20, "restart_after_reset");
    for (int i = 0; i < 255; i++) begin
      pulse_force();
      push_exp(32'hA57101D5, 1'b1);
      wait_busy(1'b0, 400, "chain_end");
      wait_busy(1'b1, 20, "chain_start");
    end
    wait_done(1000, "wrap_drain");
    check_eq("count_wrap", {24'd0, frame_count}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
